// File: rtl/usb_rx_pkg.sv
// Shared types for the USB receive path: rx_packet codes, buffer FSM states, default depth.
// USB_RX_BUF_DISCARD_EN adds the DISCARD state used for packet rollback.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE = 3'b000,
    RX_IN   = 3'b001,
    RX_OUT  = 3'b010,
    RX_ACK  = 3'b011,
    RX_DATA = 3'b100,
    RX_DONE = 3'b101,
    RX_NAK  = 3'b110,
    RX_ERR  = 3'b111
  } rx_packet_t;

`ifdef USB_RX_BUF_DISCARD_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_DISCARD = 2'd3
  } buf_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } buf_state_t;
`endif

  localparam int USB_RX_DEPTH = 64;

  function automatic logic is_token(input logic [2:0] code);
    return (code == RX_IN) || (code == RX_OUT) || (code == RX_ACK) || (code == RX_NAK);
  endfunction

endpackage

// File: rtl/usb_rx_fifo_mem.sv
// DEPTH x 8 register array: synchronous write, asynchronous (same-cycle) read.
// No reset on the storage; contents are only meaningful once written.
module usb_rx_fifo_mem
  import usb_rx_pkg::*;
#(
  parameter int DEPTH  = USB_RX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// Packet-committing RX byte FIFO; bytes become readable one cycle after the end-of-packet change (COMMIT).
// Define USB_RX_BUF_DISCARD_EN to roll back packets ending in ERR, a token, or overflow; overflowing bytes are dropped.
module usb_rx_packet_buffer
  import usb_rx_pkg::*;
#(
  parameter int DEPTH  = USB_RX_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [2:0]      rx_packet,
  input  logic [7:0]      rx_packet_data,
  input  logic            store_rx_packet_data,
  input  logic            get_rx_data,
  input  logic            flush,
  output logic [7:0]      rx_data,
  output logic [ADDR_W:0] buffer_occupancy,
  output logic            rx_data_ready,
  output logic            rx_error,
  output logic            overflow
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  buf_state_t      r_state;
  buf_state_t      w_state_nxt;
  logic [2:0]      r_prev;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] r_cm_ptr;
  logic [ADDR_W:0] r_wr_ptr;
  logic            r_overflow;
  logic            r_rx_data_ready;
  logic            w_chg;
  logic            w_in_recv;
  logic            w_full;
  logic            w_wr_en;
  logic            w_drop;
  logic            w_pop;
  logic            w_end;
  logic [ADDR_W:0] w_count;

  assign w_chg     = (rx_packet != r_prev);
  assign w_count   = r_cm_ptr - r_rd_ptr;
  assign w_full    = ((r_wr_ptr - r_rd_ptr) == LP_DEPTH);
  assign w_in_recv = (r_state == ST_RECV);
  assign w_wr_en   = w_in_recv && store_rx_packet_data && !w_full && !flush;
  assign w_drop    = w_in_recv && store_rx_packet_data && w_full;
  assign w_pop     = get_rx_data && (w_count != '0);
  assign w_end     = (rx_packet == RX_DONE) || (rx_packet == RX_ERR) || is_token(rx_packet);

`ifdef USB_RX_BUF_DISCARD_EN
  logic r_pkt_bad;
  logic r_rx_error;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_chg && rx_packet == RX_DATA) w_state_nxt = ST_RECV;
      ST_RECV: begin
        // A byte dropped on the same edge as DONE still poisons the packet.
        if (w_chg && w_end) begin
          if (rx_packet == RX_DONE && !r_pkt_bad && !w_drop) w_state_nxt = ST_COMMIT;
          else                                               w_state_nxt = ST_DISCARD;
        end
      end
      ST_COMMIT:  w_state_nxt = ST_IDLE;
      ST_DISCARD: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end
`else
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_chg && rx_packet == RX_DATA) w_state_nxt = ST_RECV;
      ST_RECV:   if (w_chg && w_end) w_state_nxt = ST_COMMIT;
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state         <= ST_IDLE;
      r_prev          <= RX_IDLE;
      r_rd_ptr        <= '0;
      r_cm_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_overflow      <= 1'b0;
      r_rx_data_ready <= 1'b0;
    end else begin
      r_prev          <= rx_packet;
      r_rx_data_ready <= 1'b0;
      if (flush) begin
        r_state    <= ST_IDLE;
        r_rd_ptr   <= '0;
        r_cm_ptr   <= '0;
        r_wr_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        if (w_pop)   r_rd_ptr   <= r_rd_ptr + 1'b1;
        if (w_wr_en) r_wr_ptr   <= r_wr_ptr + 1'b1;
        if (w_drop)  r_overflow <= 1'b1;
        if (r_state == ST_COMMIT) begin
          r_cm_ptr        <= r_wr_ptr;
          r_rx_data_ready <= 1'b1;
        end
`ifdef USB_RX_BUF_DISCARD_EN
        if (r_state == ST_DISCARD) begin
          r_wr_ptr <= r_cm_ptr;
        end
`endif
      end
    end
  end

`ifdef USB_RX_BUF_DISCARD_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pkt_bad  <= 1'b0;
      r_rx_error <= 1'b0;
    end else begin
      r_rx_error <= 1'b0;
      if (flush) begin
        r_pkt_bad <= 1'b0;
      end else if (r_state == ST_COMMIT || r_state == ST_DISCARD) begin
        r_pkt_bad  <= 1'b0;
        r_rx_error <= (r_state == ST_DISCARD);
      end else if (w_drop) begin
        r_pkt_bad <= 1'b1;
      end
    end
  end

  assign rx_error = r_rx_error;
`else
  assign rx_error = 1'b0;
`endif

  usb_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_wr_en (w_wr_en),
    .i_waddr (r_wr_ptr[ADDR_W-1:0]),
    .i_wdata (rx_packet_data),
    .i_raddr (r_rd_ptr[ADDR_W-1:0]),
    .o_rdata (rx_data)
  );

  assign buffer_occupancy = w_count;
  assign rx_data_ready    = r_rx_data_ready;
  assign overflow         = r_overflow;

endmodule

// File: doc/usb_rx_packet_buffer.md
# usb_rx_packet_buffer

Downstream consumer of `usb_rx`: captures each decoded payload byte strobed by `store_rx_packet_data` into a circular byte FIFO. Bytes stay hidden until the packet ends cleanly; a packet ending in error is rolled back. The AHB-Lite slave side drains committed bytes through a first-word-fall-through read port and sees committed occupancy for the endpoint's bulk-OUT path.

## Interface
Parameters:
- `DEPTH`, 64: FIFO size in bytes; power of two, 8..256.
- `ADDR_W`, `$clog2(DEPTH)`: pointer index width; pointers carry one extra wrap bit.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `rx_packet`  in  3  packet status from `usb_rx`, held as a level.
- `rx_packet_data`  in  8  decoded byte from `usb_rx`.
- `store_rx_packet_data`  in  1  one-cycle write strobe for `rx_packet_data`.
- `get_rx_data`  in  1  pop strobe from the AHB side.
- `flush`  in  1  synchronous clear of the whole buffer.
- `rx_data`  out  8  head committed byte (FWFT).
- `buffer_occupancy`  out  ADDR_W+1  committed bytes available (0..DEPTH).
- `rx_data_ready`  out  1  one-cycle pulse when a data packet commits.
- `rx_error`  out  1  one-cycle pulse when a packet is discarded.
- `overflow`  out  1  sticky; set on a write to a full buffer; cleared by `flush` or reset.

## Operation
- `rx_packet` codes (package): IDLE 000, IN 001, OUT 010, ACK 011, DATA 100, DONE 101, NAK 110, ERR 111.
- Events are decoded on a change of `rx_packet` against a registered copy (`rx_packet != prev`), not on the level itself.
- Pointers:
  - `rd_ptr`: read position.
  - `cm_ptr`: commit point, start of the current packet.
  - `wr_ptr`: speculative write position.
  - All are ADDR_W+1 bits wide and wrap modulo 2·DEPTH.
- Counts:
  - Committed count = `cm_ptr − rd_ptr`.
  - Full when `wr_ptr − rd_ptr == DEPTH`.
- FSM:
  - IDLE: change to DATA → RECV. Any other change → stay in IDLE.
  - RECV: on `store_rx_packet_data`, write `mem[wr_ptr]` and increment `wr_ptr`.
    - If full: drop the byte, set `overflow`, set the internal `pkt_bad`.
  - RECV, change to DONE:
    - `pkt_bad` = 0 → COMMIT.
    - Otherwise → DISCARD.
  - RECV, change to ERR, or to any token code (001/010/011/110) → DISCARD.
  - COMMIT (one cycle): `cm_ptr <= wr_ptr`, pulse `rx_data_ready`, clear `pkt_bad` → IDLE.
  - DISCARD (one cycle): `wr_ptr <= cm_ptr`, pulse `rx_error`, clear `pkt_bad` → IDLE.
- Strobes outside RECV are ignored: no write, no flag.
- Read port:
  - `rx_data = mem[rd_ptr[ADDR_W-1:0]]`.
  - `get_rx_data` with committed count > 0 increments `rd_ptr`.
  - `get_rx_data` with committed count 0 is ignored, with no underflow.
- `flush` outranks everything:
  - All pointers go to 0.
  - `overflow` and `pkt_bad` clear.
  - FSM goes to IDLE.
  - No pulses are emitted.
- Reset state:
  - All pointers 0, FSM IDLE, `prev` = IDLE.
  - `rx_data_ready`, `rx_error`, `overflow` = 0.
  - `buffer_occupancy` = 0.
  - `rx_data` = don't-care (mem is not reset).

## Timing
- A write strobe at edge N makes the byte visible to nothing until COMMIT.
- DONE change sampled at edge N:
  - FSM is COMMIT after N.
  - `cm_ptr`, `buffer_occupancy` and the `rx_data_ready` pulse all update after edge N+1.
- Pop at edge N: `rd_ptr`, `rx_data` and `buffer_occupancy` update after N.
- Simultaneous events:
  - Pop and write in the same cycle: both take effect.
  - Pop and COMMIT in the same cycle: occupancy = old + packet length − 1.
  - Strobe on the same edge as the DONE change: the byte is written before the commit.
- Reset asserted mid-packet: the packet is lost and committed data is cleared. No pulse fires after release.

## Configuration
- `USB_RX_BUF_DISCARD_EN` defined: behaviour exactly as in Operation (rollback on ERR, token interrupt or overflow).
- Not defined:
  - DISCARD state and `pkt_bad` are compiled out.
  - Every exit from RECV commits, including ERR and overflow cases.
  - Written bytes always become visible.
  - `rx_error` is tied to 0.
  - `overflow` still sets and overflowing bytes are still dropped.

## Structure
- Package `usb_rx_pkg`: `rx_packet` code enum (shared with `usb_rx`), FSM state enum, `DEPTH` default.
- One sub-module, `usb_rx_fifo_mem`: 1-write/1-read-async register array, DEPTH×8.
- All pointers and the FSM stay in the top level.

## Test plan
- Reset → `buffer_occupancy` 0, `overflow` 0, no pulses for 10 cycles.
- Happy path: DATA, strobe 0xAA, 0xAF, 0xFF, 0xE8, then DONE.
  - Before DONE: occupancy stays 0.
  - After DONE: `rx_data_ready` pulses once, occupancy 4, `rx_data` 0xAA.
  - 4 pops → 0xAA, 0xAF, 0xFF, 0xE8, then occupancy 0.
- Error path: commit 2 bytes, then DATA, strobe 3 bytes, then ERR.
  - `rx_error` pulses, occupancy stays 2.
  - Next packet 0x11, DONE → `rx_data` after 2 pops is 0x11.
- Overflow and wrap (DEPTH 64):
  - Commit 60 bytes, pop 60.
  - Then a 64-byte packet → commits, pointers wrap, occupancy 64.
  - A 65th strobe in the next packet → `overflow` 1, that packet discarded.
- Empty pop and simultaneous events:
  - Pop at occupancy 0 → no change.
  - Pop on the COMMIT cycle of a 3-byte packet with 1 committed → occupancy 3.
- `flush` mid-RECV with 5 bytes committed → occupancy 0, `overflow` 0, FSM IDLE.
  - A following DONE produces no `rx_data_ready`.
